// File: rtl/seq_mult_digit_if.sv
// Handshake bundle for seq_mult_digit: operand channel in, product channel out,
// plus the busy status flag. The slave side is the multiplier itself.
interface seq_mult_digit_if #(
    parameter int AW = 8,
    parameter int BW = 9
);
    localparam int PW = AW + BW;

    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_a;
    logic [BW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_p;
    logic          busy;

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_p,
        output busy
    );

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_p,
        input  busy
    );
endinterface

// File: rtl/seq_mult_digit.sv
// Iterative unsigned multiplier. A is consumed as 2-bit digits and B as 3-bit
// digits; one 2x3 digit product per cycle is shifted to its weight and added
// into a full-width accumulator. B digit index j is the inner loop, A digit
// index i the outer loop, so the partial sums follow a fixed sequence.
module seq_mult_digit #(
    parameter int A_DIGITS = 4,
    parameter int B_DIGITS = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_mult_digit_if.slave bus
);
    localparam int AW = 2 * A_DIGITS;
    localparam int BW = 3 * B_DIGITS;
    localparam int PW = AW + BW;
    localparam int IW = (A_DIGITS > 1) ? $clog2(A_DIGITS) : 1;
    localparam int JW = (B_DIGITS > 1) ? $clog2(B_DIGITS) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(A_DIGITS - 1);
    localparam logic [JW-1:0] J_LAST = JW'(B_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [AW-1:0] a_reg;
    logic [BW-1:0] b_reg;
    logic [PW-1:0] acc;
    logic [PW-1:0] acc_next;
    logic [PW-1:0] addend;
    logic [PW-1:0] out_p_reg;
    logic [IW-1:0] i_idx;
    logic [JW-1:0] j_idx;
    logic [1:0]    a_dig;
    logic [2:0]    b_dig;
    logic [4:0]    dprod;
    logic          accept;
    logic          last_step;

    // Digit-product stage: select the current digit pair, multiply, shift to weight 2i+3j and add.
    always_comb begin
        a_dig     = a_reg[2*i_idx +: 2];
        b_dig     = b_reg[3*j_idx +: 3];
        dprod     = {3'b000, a_dig} * {2'b00, b_dig};
        addend    = PW'(dprod) << (2*i_idx + 3*j_idx);
        acc_next  = acc + addend;
        last_step = (i_idx == I_LAST) && (j_idx == J_LAST);
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, step through all digit pairs in RUN, hold in DONE until taken.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                accept = bus.in_valid;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Handshake and status outputs are pure decodes of the state.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
        bus.out_p     = out_p_reg;
    end

    // Operand capture, digit indices, accumulation and product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            i_idx     <= '0;
            j_idx     <= '0;
            out_p_reg <= '0;
        end else if (accept) begin
            a_reg <= bus.in_a;
            b_reg <= bus.in_b;
            acc   <= '0;
            i_idx <= '0;
            j_idx <= '0;
        end else if (state == RUN) begin
            acc <= acc_next;
            if (last_step) begin
                i_idx     <= '0;
                j_idx     <= '0;
                out_p_reg <= acc_next;
            end else if (j_idx == J_LAST) begin
                j_idx <= '0;
                i_idx <= i_idx + 1'b1;
            end else begin
                j_idx <= j_idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_mult_digit.sv
// Directed-vector bench for seq_mult_digit: reset values, latency, per-step
// partial sums, output stall, mid-operation reset and back-to-back operation.
module tb_seq_mult_digit;
    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    seq_mult_digit_if #(.AW(8), .BW(9)) bus ();

    seq_mult_digit #(.A_DIGITS(4), .B_DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Absolute time limit so a stuck design still terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Present operands for one cycle; caller guarantees in_ready is high.
    task automatic start_op(input logic [7:0] a, input logic [8:0] b);
        @(negedge clk);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Count clock edges after the accept edge until out_valid is seen.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!bus.out_valid && edges < 100) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        #12;
        total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %0d, expected 1", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %0d, expected 0", bus.out_valid); else passed++;
        total++; if (bus.out_p !== 17'd0) $display("[TB] FAIL reset_out_p: got %0d, expected 0", bus.out_p); else passed++;
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0d, expected 0", bus.busy); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL idle_in_ready: got %0d, expected 1", bus.in_ready); else passed++;
    endtask

    task automatic test_max_operands();
        int e;
        bus.out_ready = 1'b1;
        start_op(8'd255, 9'd511);
        total++; if (bus.busy !== 1'b1) $display("[TB] FAIL max_busy: got %0d, expected 1", bus.busy); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL max_in_ready_run: got %0d, expected 0", bus.in_ready); else passed++;
        wait_done(e);
        total++; if (e !== 12) $display("[TB] FAIL max_latency: got %0d, expected 12", e); else passed++;
        total++; if (bus.out_p !== 17'd130305) $display("[TB] FAIL max_product: got %0d, expected 130305", bus.out_p); else passed++;
        @(negedge clk);
        total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL max_in_ready_after: got %0d, expected 1", bus.in_ready); else passed++;
        total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL max_out_valid_after: got %0d, expected 0", bus.out_valid); else passed++;
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL max_busy_after: got %0d, expected 0", bus.busy); else passed++;
        total++; if (bus.out_p !== 17'd130305) $display("[TB] FAIL max_product_hold: got %0d, expected 130305", bus.out_p); else passed++;
    endtask

    task automatic test_small_operands();
        logic [7:0]  va [3] = '{8'd0, 8'd1, 8'd6};
        logic [8:0]  vb [3] = '{9'd0, 9'd1, 9'd5};
        logic [16:0] vp [3] = '{17'd0, 17'd1, 17'd30};
        int e;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start_op(va[k], vb[k]);
            wait_done(e);
            total++; if (e !== 12) $display("[TB] FAIL small_latency[%0d]: got %0d, expected 12", k, e); else passed++;
            total++; if (bus.out_p !== vp[k]) $display("[TB] FAIL small_product[%0d]: got %0d, expected %0d", k, bus.out_p, vp[k]); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_step_order();
        logic [16:0] exp_acc [13] = '{17'd0, 17'd3, 17'd3, 17'd451, 17'd463, 17'd463, 17'd2255,
                                      17'd2351, 17'd2351, 17'd16687, 17'd17071, 17'd17071, 17'd74415};
        bus.out_ready = 1'b1;
        start_op(8'hA5, 9'h1C3);
        total++; if (dut.acc !== exp_acc[0]) $display("[TB] FAIL step_acc[0]: got %0d, expected %0d", dut.acc, exp_acc[0]); else passed++;
        for (int k = 1; k < 13; k++) begin
            @(negedge clk);
            total++; if (dut.acc !== exp_acc[k]) $display("[TB] FAIL step_acc[%0d]: got %0d, expected %0d", k, dut.acc, exp_acc[k]); else passed++;
        end
        total++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL step_out_valid: got %0d, expected 1", bus.out_valid); else passed++;
        total++; if (bus.out_p !== 17'd74415) $display("[TB] FAIL step_product: got %0d, expected 74415", bus.out_p); else passed++;
        @(negedge clk);
    endtask

    task automatic test_stall();
        int e;
        bus.out_ready = 1'b0;
        start_op(8'd100, 9'd200);
        wait_done(e);
        total++; if (e !== 12) $display("[TB] FAIL stall_latency: got %0d, expected 12", e); else passed++;
        total++; if (bus.out_p !== 17'd20000) $display("[TB] FAIL stall_product: got %0d, expected 20000", bus.out_p); else passed++;
        for (int k = 0; k < 20; k++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 8'(7 + k);
            bus.in_b     = 9'(9 + k);
            @(negedge clk);
            total++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL stall_out_valid[%0d]: got %0d, expected 1", k, bus.out_valid); else passed++;
            total++; if (bus.out_p !== 17'd20000) $display("[TB] FAIL stall_out_p[%0d]: got %0d, expected 20000", k, bus.out_p); else passed++;
            total++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL stall_in_ready[%0d]: got %0d, expected 0", k, bus.in_ready); else passed++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL stall_release_valid: got %0d, expected 0", bus.out_valid); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL stall_release_ready: got %0d, expected 1", bus.in_ready); else passed++;
        total++; if (bus.out_p !== 17'd20000) $display("[TB] FAIL stall_release_out_p: got %0d, expected 20000", bus.out_p); else passed++;
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL stall_release_busy: got %0d, expected 0", bus.busy); else passed++;
    endtask

    task automatic test_reset_mid_run();
        int e;
        bus.out_ready = 1'b1;
        start_op(8'd200, 9'd300);
        repeat (5) @(negedge clk);
        total++; if (bus.busy !== 1'b1) $display("[TB] FAIL midrst_busy_before: got %0d, expected 1", bus.busy); else passed++;
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL midrst_out_valid: got %0d, expected 0", bus.out_valid); else passed++;
        total++; if (bus.out_p !== 17'd0) $display("[TB] FAIL midrst_out_p: got %0d, expected 0", bus.out_p); else passed++;
        total++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL midrst_in_ready: got %0d, expected 1", bus.in_ready); else passed++;
        total++; if (bus.busy !== 1'b0) $display("[TB] FAIL midrst_busy: got %0d, expected 0", bus.busy); else passed++;
        total++; if (dut.acc !== 17'd0) $display("[TB] FAIL midrst_acc: got %0d, expected 0", dut.acc); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        start_op(8'd3, 9'd7);
        wait_done(e);
        total++; if (e !== 12) $display("[TB] FAIL midrst_latency: got %0d, expected 12", e); else passed++;
        total++; if (bus.out_p !== 17'd21) $display("[TB] FAIL midrst_product: got %0d, expected 21", bus.out_p); else passed++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int          acc_cyc [2];
        logic [16:0] prod [2];
        int          n_acc;
        int          n_out;
        acc_cyc[0]    = 0;
        acc_cyc[1]    = 0;
        prod[0]       = '0;
        prod[1]       = '0;
        n_acc         = 0;
        n_out         = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_a      = 8'd18;
        bus.in_b      = 9'd52;
        bus.in_valid  = 1'b1;
        for (int c = 0; c < 60 && n_out < 2; c++) begin
            if (n_acc == 1) begin
                bus.in_a = 8'd155;
                bus.in_b = 9'd257;
            end
            if (n_acc == 2) begin
                bus.in_valid = 1'b0;
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            if (bus.out_valid && bus.out_ready) begin
                prod[n_out] = bus.out_p;
                n_out++;
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        total++; if (acc_cyc[1] - acc_cyc[0] !== 14) $display("[TB] FAIL b2b_spacing: got %0d, expected 14", acc_cyc[1] - acc_cyc[0]); else passed++;
        total++; if (prod[0] !== 17'd936) $display("[TB] FAIL b2b_product0: got %0d, expected 936", prod[0]); else passed++;
        total++; if (prod[1] !== 17'd39835) $display("[TB] FAIL b2b_product1: got %0d, expected 39835", prod[1]); else passed++;
    endtask

    // Run every scenario in order, then report.
    initial begin
        $display("[TB] starting seq_mult_digit bench");
        test_reset();
        test_max_operands();
        test_small_operands();
        test_step_order();
        test_stall();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
